// File: rtl/mips_fetch.sv
// Instruction fetch and next-PC unit: owns the PC, fetches words over a
// req/ack handshake, hands them to decode over valid/ready and resolves
// jumps, branches and the wrong-instruction trap when an instruction is consumed.
module mips_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_instr,
    output logic [5:0]  o_opcode,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    output logic [31:0] o_pc_plus4,
    input  logic        i_jmp_en,
    input  logic        i_beq_en,
    input  logic        i_bne_en,
    input  logic        i_wrong_instruction,
    input  logic        i_alu_zero,
    output logic        o_exception,
    output logic [31:0] o_epc,
    output logic [31:0] o_instr_count
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_VALID} state_t;

    state_t      state;
    state_t      state_next;
    logic        fetch_done;
    logic        consume;
    logic        branch_taken;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;
    logic [31:0] jump_target;
    logic [31:0] branch_target;

    assign o_imem_addr = pc;
    assign o_pc_plus4  = pc_plus4;
    assign o_opcode    = o_instr[31:26];

    // State register; reset parks the FSM in S_IDLE from any state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the handshake outputs and the accept/consume strobes.
    always_comb begin
        state_next    = state;
        o_imem_req    = 1'b0;
        o_instr_valid = 1'b0;
        fetch_done    = 1'b0;
        consume       = 1'b0;
        case (state)
            S_IDLE: begin
                state_next = S_FETCH;
            end
            S_FETCH: begin
                o_imem_req = 1'b1;
                if (i_imem_ack) begin
                    fetch_done = 1'b1;
                    state_next = S_VALID;
                end
            end
            S_VALID: begin
                o_instr_valid = 1'b1;
                if (i_instr_ready) begin
                    consume    = 1'b1;
                    state_next = S_FETCH;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Next-PC selection; the trap has priority and is applied in the register block.
    always_comb begin
        jump_target   = {pc_plus4[31:28], o_instr[25:0], 2'b00};
        branch_target = pc_plus4 + {{14{o_instr[15]}}, o_instr[15:0], 2'b00};
        branch_taken  = (i_beq_en & i_alu_zero) | (i_bne_en & ~i_alu_zero);
        if (i_jmp_en) begin
            pc_next = jump_target;
        end else if (branch_taken) begin
            pc_next = branch_target;
        end else begin
            pc_next = pc_plus4;
        end
    end

    // PC, held instruction, EPC, exception pulse and consume counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc            <= RESET_VECTOR;
            pc_plus4      <= RESET_VECTOR + 32'd4;
            o_instr       <= 32'h0;
            o_epc         <= 32'h0;
            o_instr_count <= 32'h0;
            o_exception   <= 1'b0;
        end else begin
            o_exception <= 1'b0;
            if (fetch_done) begin
                o_instr <= i_imem_rdata;
            end
            if (consume) begin
                o_instr_count <= o_instr_count + 32'd1;
                if (i_wrong_instruction) begin
                    o_epc       <= pc;
                    pc          <= EXC_VECTOR;
                    pc_plus4    <= EXC_VECTOR + 32'd4;
                    o_exception <= 1'b1;
                end else begin
                    pc       <= pc_next;
                    pc_plus4 <= pc_next + 32'd4;
                end
            end
        end
    end

endmodule

// File: tb/tb_mips_fetch.sv
// Directed bench for mips_fetch: small instruction memory responder with
// programmable wait states, hand-computed expected PCs and counters.
module tb_mips_fetch;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack;
    logic [31:0] i_imem_rdata;
    logic [31:0] o_instr;
    logic [5:0]  o_opcode;
    logic        o_instr_valid;
    logic        i_instr_ready;
    logic [31:0] o_pc_plus4;
    logic        i_jmp_en;
    logic        i_beq_en;
    logic        i_bne_en;
    logic        i_wrong_instruction;
    logic        i_alu_zero;
    logic        o_exception;
    logic [31:0] o_epc;
    logic [31:0] o_instr_count;

    int passed = 0;
    int total  = 0;
    int mem_delay = 0;
    int wait_cnt  = 0;
    logic force_ack = 1'b0;

    mips_fetch dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
        .i_imem_ack(i_imem_ack), .i_imem_rdata(i_imem_rdata),
        .o_instr(o_instr), .o_opcode(o_opcode),
        .o_instr_valid(o_instr_valid), .i_instr_ready(i_instr_ready),
        .o_pc_plus4(o_pc_plus4),
        .i_jmp_en(i_jmp_en), .i_beq_en(i_beq_en), .i_bne_en(i_bne_en),
        .i_wrong_instruction(i_wrong_instruction), .i_alu_zero(i_alu_zero),
        .o_exception(o_exception), .o_epc(o_epc), .o_instr_count(o_instr_count)
    );

    always #5 i_clk = ~i_clk;

    // Memory contents: nops at 0x0..0xC, a jump at 0x10, beq at 0x100,
    // a jump to 0x24 at 0x518, otherwise an address-tagged word.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'h0, 32'h4, 32'h8, 32'hC: mem_word = 32'h0000_0000;
            32'h10:  mem_word = 32'h0800_0040;
            32'h100: mem_word = 32'h1000_FFFF;
            32'h518: mem_word = 32'h0800_0009;
            default: mem_word = 32'hA000_0000 | addr;
        endcase
    endfunction

    // Memory responder: acks after mem_delay request cycles, evaluated on the falling edge.
    always @(negedge i_clk) begin
        if (o_imem_req) begin
            if (wait_cnt >= mem_delay) begin
                i_imem_ack   = 1'b1;
                i_imem_rdata = mem_word(o_imem_addr);
                wait_cnt     = 0;
            end else begin
                i_imem_ack = 1'b0;
                wait_cnt   = wait_cnt + 1;
            end
        end else begin
            i_imem_ack   = force_ack;
            i_imem_rdata = 32'hDEAD_BEEF;
            wait_cnt     = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_valid(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (o_instr_valid) break;
            step();
        end
        check("valid_wait", {31'b0, o_instr_valid}, 32'd1);
    endtask

    task automatic consume(input logic jmp, input logic beq, input logic bne,
                           input logic wrong, input logic zero);
        i_jmp_en = jmp; i_beq_en = beq; i_bne_en = bne;
        i_wrong_instruction = wrong; i_alu_zero = zero;
        i_instr_ready = 1'b1;
        step();
        i_jmp_en = 0; i_beq_en = 0; i_bne_en = 0;
        i_wrong_instruction = 0; i_alu_zero = 0;
        i_instr_ready = 1'b0;
    endtask

    initial begin
        i_rst = 1'b1; i_instr_ready = 0; i_imem_ack = 0; i_imem_rdata = 0;
        i_jmp_en = 0; i_beq_en = 0; i_bne_en = 0; i_wrong_instruction = 0; i_alu_zero = 0;
        step(); step();
        check("rst_req", {31'b0, o_imem_req}, 32'd0);
        check("rst_valid", {31'b0, o_instr_valid}, 32'd0);
        check("rst_addr", o_imem_addr, 32'h0);
        check("rst_pc4", o_pc_plus4, 32'h4);
        check("rst_count", o_instr_count, 32'h0);
        check("rst_epc", o_epc, 32'h0);
        check("rst_instr", o_instr, 32'h0);
        check("rst_exc", {31'b0, o_exception}, 32'd0);

        // Sequential nops, zero-wait memory
        i_rst = 1'b0;
        step();
        check("first_req", {31'b0, o_imem_req}, 32'd1);
        check("first_addr", o_imem_addr, 32'h0);
        step();
        check("zw_valid", {31'b0, o_instr_valid}, 32'd1);
        check("zw_pc4", o_pc_plus4, 32'h4);
        consume(0, 0, 0, 0, 0);
        check("seq_addr1", o_imem_addr, 32'h4);
        check("seq_req1", {31'b0, o_imem_req}, 32'd1);
        check("count1", o_instr_count, 32'd1);

        // Three wait states at 0x4: request held for four cycles
        mem_delay = 3;
        for (int k = 0; k < 4; k++) begin
            check("wait_req", {31'b0, o_imem_req}, 32'd1);
            check("wait_addr", o_imem_addr, 32'h4);
            check("wait_novalid", {31'b0, o_instr_valid}, 32'd0);
            if (k < 3) step();
        end
        step();
        mem_delay = 0;
        check("wait_valid", {31'b0, o_instr_valid}, 32'd1);
        consume(0, 0, 0, 0, 0);
        check("seq_addr2", o_imem_addr, 32'h8);
        step();
        check("seq_valid3", {31'b0, o_instr_valid}, 32'd1);
        consume(0, 0, 0, 0, 0);
        check("count3", o_instr_count, 32'd3);
        check("seq_addr3", o_imem_addr, 32'hC);
        wait_valid(10);
        consume(0, 0, 0, 0, 0);
        check("seq_addr4", o_imem_addr, 32'h10);

        // Jump at 0x10 to 0x100
        wait_valid(10);
        check("jmp_instr", o_instr, 32'h0800_0040);
        check("jmp_opcode", {26'b0, o_opcode}, 32'd2);
        consume(1, 0, 0, 0, 0);
        check("jmp_addr", o_imem_addr, 32'h100);

        // beq at 0x100, imm -1: taken loops to 0x100, not taken falls through
        wait_valid(10);
        check("beq_instr", o_instr, 32'h1000_FFFF);
        check("beq_pc4", o_pc_plus4, 32'h104);
        consume(0, 1, 0, 0, 1);
        check("beq_taken", o_imem_addr, 32'h100);
        wait_valid(10);
        consume(0, 1, 0, 0, 0);
        check("beq_not_taken", o_imem_addr, 32'h104);

        // bne at 0x104 (imm 0x104): 0x108 + 0x410
        wait_valid(10);
        consume(0, 0, 1, 0, 0);
        check("bne_taken", o_imem_addr, 32'h518);

        // Jump at 0x518 to 0x24
        wait_valid(10);
        consume(1, 0, 0, 0, 0);
        check("jmp_24", o_imem_addr, 32'h24);

        // Trap at 0x24 with a competing jump
        wait_valid(10);
        check("pre_trap_exc", {31'b0, o_exception}, 32'd0);
        consume(1, 0, 0, 1, 0);
        check("trap_exc", {31'b0, o_exception}, 32'd1);
        check("trap_epc", o_epc, 32'h24);
        check("trap_addr", o_imem_addr, 32'h80);
        check("trap_req", {31'b0, o_imem_req}, 32'd1);
        check("trap_count", o_instr_count, 32'd10);
        step();
        check("trap_pulse_end", {31'b0, o_exception}, 32'd0);

        // Ready held low in S_VALID
        for (int k = 0; k < 5; k++) begin
            check("stall_valid", {31'b0, o_instr_valid}, 32'd1);
            check("stall_noreq", {31'b0, o_imem_req}, 32'd0);
            check("stall_instr", o_instr, 32'hA000_0080);
            check("stall_pc4", o_pc_plus4, 32'h84);
            check("stall_count", o_instr_count, 32'd10);
            step();
        end
        consume(0, 0, 0, 0, 0);
        check("post_stall_addr", o_imem_addr, 32'h84);
        check("post_stall_count", o_instr_count, 32'd11);

        // Reset during S_FETCH, then an ack while idle
        i_rst = 1'b1;
        step();
        check("rstf_req", {31'b0, o_imem_req}, 32'd0);
        check("rstf_valid", {31'b0, o_instr_valid}, 32'd0);
        check("rstf_count", o_instr_count, 32'd0);
        check("rstf_addr", o_imem_addr, 32'h0);
        check("rstf_epc", o_epc, 32'h0);
        i_rst = 1'b0;
        force_ack = 1'b1;
        step();
        force_ack = 1'b0;
        check("idle_ack_req", {31'b0, o_imem_req}, 32'd1);
        check("idle_ack_addr", o_imem_addr, 32'h0);
        check("idle_ack_novalid", {31'b0, o_instr_valid}, 32'd0);
        check("idle_ack_instr", o_instr, 32'h0);
        wait_valid(10);
        consume(0, 0, 0, 0, 0);
        check("restart_addr", o_imem_addr, 32'h4);
        check("restart_count", o_instr_count, 32'd1);

        // Reset during S_VALID with ready high: instruction dropped
        wait_valid(10);
        i_rst = 1'b1;
        i_instr_ready = 1'b1;
        step();
        i_instr_ready = 1'b0;
        check("rstv_req", {31'b0, o_imem_req}, 32'd0);
        check("rstv_valid", {31'b0, o_instr_valid}, 32'd0);
        check("rstv_count", o_instr_count, 32'd0);
        i_rst = 1'b0;
        step();
        check("rstv_restart_addr", o_imem_addr, 32'h0);
        check("rstv_restart_req", {31'b0, o_imem_req}, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
